// File: rtl/cu_pkg.sv
// Shared control-unit definitions: sequencer states, CON bit indices and opcodes.
// Datapath blocks import this package to decode the CON word.
package cu_pkg;

    localparam int unsigned CON_W = 32;
    localparam int unsigned OP_W  = 8;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F1   = 4'd1,
        ST_F2   = 4'd2,
        ST_F3   = 4'd3,
        ST_DEC  = 4'd4,
        ST_E1   = 4'd5,
        ST_E2   = 4'd6,
        ST_E3   = 4'd7,
        ST_HLT  = 4'd8
    } cu_state_e;

    // CON bit positions, one per micro-operation
    localparam int unsigned CON_MAR_PC  = 0;   // MAR <= PC
    localparam int unsigned CON_MBR_MEM = 1;   // MBR <= MEM[MAR]
    localparam int unsigned CON_PC_MBR  = 2;   // PC  <= MBR[7:0]
    localparam int unsigned CON_IR_MBR  = 3;   // IR  <= MBR
    localparam int unsigned CON_MAR_MBR = 4;   // MAR <= MBR[7:0]
    localparam int unsigned CON_MEM_MBR = 5;   // MEM[MAR] <= MBR
    localparam int unsigned CON_MBR_ACC = 6;   // MBR <= ACC
    localparam int unsigned CON_ACC_ADD = 8;   // ACC <= ACC + MBR
    localparam int unsigned CON_ACC_SUB = 9;   // ACC <= ACC - MBR
    localparam int unsigned CON_ACC_LD  = 10;  // ACC <= MBR
    localparam int unsigned CON_PC_INC  = 14;  // PC  <= PC + 1

    typedef logic [OP_W-1:0] cu_op_t;

    localparam cu_op_t OP_LOAD   = 8'h01;
    localparam cu_op_t OP_STORE  = 8'h02;
    localparam cu_op_t OP_ADD    = 8'h03;
    localparam cu_op_t OP_SUB    = 8'h04;
    localparam cu_op_t OP_JMPGEZ = 8'h05;
    localparam cu_op_t OP_JMP    = 8'h06;
    localparam cu_op_t OP_HALT   = 8'h07;

    function automatic logic [CON_W-1:0] con_bit(input int unsigned idx);
        return CON_W'(1) << idx;
    endfunction

    // Opcodes that need the three-step memory operand sequence
    function automatic logic op_is_mem(input cu_op_t op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic op_is_jump(input cu_op_t op);
        return (op == OP_JMP) || (op == OP_JMPGEZ);
    endfunction

endpackage

// File: rtl/cu_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/status inputs and the control word outputs.
interface cu_sequencer_if;
    import cu_pkg::*;

    logic [OP_W-1:0]  ir_op;
    logic             acc_neg;
    logic [CON_W-1:0] con;
    logic             halt;
    logic             instr_done;

    modport master (output ir_op, acc_neg, input  con, halt, instr_done);
    modport slave  (input  ir_op, acc_neg, output con, halt, instr_done);

endinterface

// File: rtl/cu_sequencer_fsm.sv
// Moore micro-sequencer: fetch, decode and execute steps with registered CON/HALT/INSTR_DONE.
module cu_sequencer_fsm
    import cu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    cu_sequencer_if.slave  bus
);

    cu_state_e        state_q, state_d;
    cu_op_t           op_q, op_d;
    logic [CON_W-1:0] con_q, con_d;
    logic             halt_q, halt_d;
    logic             done_q, done_d;
    logic             take_c;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        con_d   = '0;
        halt_d  = 1'b0;
        done_d  = 1'b0;
        take_c  = 1'b0;

        case (state_q)
            ST_IDLE: if (start_i) state_d = ST_F1;
            ST_F1:   state_d = ST_F2;
            ST_F2:   state_d = ST_F3;
            ST_F3:   state_d = ST_DEC;
            ST_DEC: begin
                op_d = bus.ir_op;
                if (bus.ir_op == OP_HALT)
                    state_d = ST_HLT;
                else if (op_is_mem(bus.ir_op) || op_is_jump(bus.ir_op))
                    state_d = ST_E1;
                else
                    state_d = ST_IDLE;
            end
            ST_E1:   state_d = op_is_mem(op_q) ? ST_E2 : ST_IDLE;
            ST_E2:   state_d = ST_E3;
            ST_E3:   state_d = ST_IDLE;
            ST_HLT:  state_d = ST_HLT;
            default: state_d = ST_IDLE;
        endcase

        // ACC_NEG is sampled only on the DEC -> E1 transition
        if (state_q == ST_DEC)
            take_c = (bus.ir_op == OP_JMP) || ((bus.ir_op == OP_JMPGEZ) && !bus.acc_neg);

        // Outputs are registered for the state being entered, so they track state_q exactly
        case (state_d)
            ST_F1:  con_d = con_bit(CON_MAR_PC);
            ST_F2:  con_d = con_bit(CON_MBR_MEM) | con_bit(CON_PC_INC);
            ST_F3:  con_d = con_bit(CON_IR_MBR);
            ST_DEC: done_d = !(op_is_mem(bus.ir_op) || op_is_jump(bus.ir_op) || (bus.ir_op == OP_HALT));
            ST_E1: begin
                if (op_is_mem(op_d)) begin
                    con_d = con_bit(CON_MAR_MBR);
                end else begin
                    done_d = 1'b1;
                    if (take_c) con_d = con_bit(CON_PC_MBR);
                end
            end
            ST_E2:  con_d = (op_d == OP_STORE) ? con_bit(CON_MBR_ACC) : con_bit(CON_MBR_MEM);
            ST_E3: begin
                done_d = 1'b1;
                if (op_d == OP_LOAD)       con_d = con_bit(CON_ACC_LD);
                else if (op_d == OP_ADD)   con_d = con_bit(CON_ACC_ADD);
                else if (op_d == OP_SUB)   con_d = con_bit(CON_ACC_SUB);
                else if (op_d == OP_STORE) con_d = con_bit(CON_MEM_MBR);
            end
            ST_HLT: halt_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            con_q   <= '0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            con_q   <= con_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
        end
    end

    assign bus.con        = con_q;
    assign bus.halt       = halt_q;
    assign bus.instr_done = done_q;

endmodule

// File: rtl/cu_step_edge.sv
// Registered rising-edge detector for the single-step input (CU_SINGLE_STEP_EN builds only).
// Reset assumes STEP was already high so a held-high STEP does not launch an instruction.
`ifdef CU_SINGLE_STEP_EN
module cu_step_edge (
    input  logic clk,
    input  logic rst,
    input  logic step_i,
    output logic rise_o
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = step_i;
        rise_d = step_i & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule
`endif

// File: rtl/cu_sequencer.sv
// Control-unit sequencer top. Define CU_SINGLE_STEP_EN to add the STEP port, which
// launches one instruction per registered rising edge instead of free-running.
module cu_sequencer
    import cu_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
`ifdef CU_SINGLE_STEP_EN
    input  logic             STEP,
`endif
    input  logic [OP_W-1:0]  IR_OP,
    input  logic             ACC_NEG,
    output logic [CON_W-1:0] CON,
    output logic             HALT,
    output logic             INSTR_DONE
);

    cu_sequencer_if bus ();
    logic start;

    assign bus.ir_op   = IR_OP;
    assign bus.acc_neg = ACC_NEG;
    assign CON         = bus.con;
    assign HALT        = bus.halt;
    assign INSTR_DONE  = bus.instr_done;

`ifdef CU_SINGLE_STEP_EN
    cu_step_edge u_step_edge (
        .clk    (CLK),
        .rst    (RST),
        .step_i (STEP),
        .rise_o (start)
    );
`else
    assign start = 1'b1;
`endif

    cu_sequencer_fsm u_fsm (
        .clk     (CLK),
        .rst     (RST),
        .start_i (start),
        .bus     (bus.slave)
    );

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: expected per-cycle {HALT, INSTR_DONE, CON} queued at
// stimulus time and compared on the falling edge. Honours CU_SINGLE_STEP_EN.
module tb_cu_sequencer;

    logic clk = 1'b0;
    logic rst;
`ifdef CU_SINGLE_STEP_EN
    logic step;
`endif

    cu_sequencer_if tb_bus ();

    cu_sequencer dut (
        .CLK        (clk),
        .RST        (rst),
`ifdef CU_SINGLE_STEP_EN
        .STEP       (step),
`endif
        .IR_OP      (tb_bus.ir_op),
        .ACC_NEG    (tb_bus.acc_neg),
        .CON        (tb_bus.con),
        .HALT       (tb_bus.halt),
        .INSTR_DONE (tb_bus.instr_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    logic [33:0] exp_q[$];
    string       tag_q[$];

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got halt=%0b done=%0b con=%h, expected halt=%0b done=%0b con=%h",
                     tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [31:0] con, input logic halt,
                              input logic done);
        exp_q.push_back({halt, done, con});
        tag_q.push_back(tag);
    endtask

    // One comparison per clock until the scoreboard is empty
    task automatic drain();
        while (exp_q.size() != 0) begin
            @(negedge clk);
`ifdef CU_SINGLE_STEP_EN
            step = 1'b0;
`endif
            check_eq(tag_q.pop_front(), {tb_bus.halt, tb_bus.instr_done, tb_bus.con},
                     exp_q.pop_front());
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) expect_cyc("reset", 32'h0, 1'b0, 1'b0);
        drain();
        rst = 1'b0;
    endtask

    task automatic start_instr(input logic [7:0] op, input logic neg);
        tb_bus.ir_op   = op;
        tb_bus.acc_neg = neg;
`ifdef CU_SINGLE_STEP_EN
        step = 1'b1;
        expect_cyc("step_wait", 32'h0, 1'b0, 1'b0);
`endif
        expect_cyc($sformatf("op%02h F1", op), 32'h0000_0001, 1'b0, 1'b0);
        expect_cyc($sformatf("op%02h F2", op), 32'h0000_4002, 1'b0, 1'b0);
        expect_cyc($sformatf("op%02h F3", op), 32'h0000_0008, 1'b0, 1'b0);
    endtask

    task automatic push_exec(input logic [7:0] op, input logic neg);
        logic nop;
        nop = !(op >= 8'h01 && op <= 8'h07);
        expect_cyc($sformatf("op%02h DEC", op), 32'h0, 1'b0, nop);
        case (op)
            8'h01: begin
                expect_cyc("LOAD E1", 32'h010, 1'b0, 1'b0);
                expect_cyc("LOAD E2", 32'h002, 1'b0, 1'b0);
                expect_cyc("LOAD E3", 32'h400, 1'b0, 1'b1);
            end
            8'h02: begin
                expect_cyc("STORE E1", 32'h010, 1'b0, 1'b0);
                expect_cyc("STORE E2", 32'h040, 1'b0, 1'b0);
                expect_cyc("STORE E3", 32'h020, 1'b0, 1'b1);
            end
            8'h03: begin
                expect_cyc("ADD E1", 32'h010, 1'b0, 1'b0);
                expect_cyc("ADD E2", 32'h002, 1'b0, 1'b0);
                expect_cyc("ADD E3", 32'h100, 1'b0, 1'b1);
            end
            8'h04: begin
                expect_cyc("SUB E1", 32'h010, 1'b0, 1'b0);
                expect_cyc("SUB E2", 32'h002, 1'b0, 1'b0);
                expect_cyc("SUB E3", 32'h200, 1'b0, 1'b1);
            end
            8'h05:   expect_cyc("JMPGEZ E1", neg ? 32'h0 : 32'h4, 1'b0, 1'b1);
            8'h06:   expect_cyc("JMP E1", 32'h4, 1'b0, 1'b1);
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [7:0] op, input logic neg);
        start_instr(op, neg);
        push_exec(op, neg);
        expect_cyc($sformatf("op%02h IDLE", op), 32'h0, 1'b0, 1'b0);
        drain();
    endtask

    initial begin
        rst            = 1'b1;
        tb_bus.ir_op   = 8'h00;
        tb_bus.acc_neg = 1'b0;
`ifdef CU_SINGLE_STEP_EN
        step           = 1'b0;
`endif
        do_reset(2);

`ifdef CU_SINGLE_STEP_EN
        for (int i = 0; i < 10; i++) expect_cyc("step_low_idle", 32'h0, 1'b0, 1'b0);
        drain();
`endif

        run_op(8'h01, 1'b0);
        run_op(8'h03, 1'b1);
        run_op(8'h04, 1'b0);
        run_op(8'h02, 1'b1);
        run_op(8'h05, 1'b0);
        run_op(8'h05, 1'b1);
        run_op(8'h06, 1'b1);
        run_op(8'hAA, 1'b0);
        run_op(8'h00, 1'b1);

        // Reset in E2 of STORE: the E3 write must never appear
        start_instr(8'h02, 1'b0);
        expect_cyc("abort DEC", 32'h0, 1'b0, 1'b0);
        expect_cyc("abort E1", 32'h010, 1'b0, 1'b0);
        expect_cyc("abort E2", 32'h040, 1'b0, 1'b0);
        drain();
        do_reset(3);
        run_op(8'h01, 1'b0);

        // Halt holds until reset
        start_instr(8'h07, 1'b0);
        expect_cyc("halt DEC", 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) expect_cyc("halted", 32'h0, 1'b1, 1'b0);
        drain();
        do_reset(2);
        run_op(8'h03, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
